// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds default widths, FSM state encoding, the queue entry layout and the NOP opcode.
package fetch_pkg;

  localparam int unsigned A_SIZE_DEF = 10;
  localparam int unsigned I_SIZE_DEF = 16;

  // Legacy-compatible state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  localparam logic [I_SIZE_DEF-1:0] NOP = 16'h0000;

  // Queue entry at default widths; the queue itself stores {instr, pc} flat
  // so non-default parameterisations keep working.
  typedef struct packed {
    logic [A_SIZE_DEF-1:0] pc;
    logic [I_SIZE_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer for fetched {instr, pc} words.
// Ports: clk, rst (async active-low), push_i/pop_i/flush_i controls,
//        wdata_i tail write data, count_o occupancy, head_o head entry.
// Flush clears pointers and count; stale storage is never visible because
// the consumer qualifies head_o with count_o != 0.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue.sv
// PC generator plus DEPTH-entry instruction prefetch queue between a
// synchronous program memory and decode.
// Ports: clk, rst (async active-low); mem_req/mem_addr/mem_rdata program
//        memory read port; jmp_sel/jmpr_sel/jmp/jmp_offset/br_pc redirect;
//        freeze global hold; instr_valid/instr_ready/instr_out/instr_pc decode.
// Optional: define FETCH_BYPASS_EN to forward a response straight to decode
// when the queue is empty (redirect-to-valid latency 2 instead of 3).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned A_SIZE = A_SIZE_DEF,
  parameter int unsigned I_SIZE = I_SIZE_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [A_SIZE-1:0] mem_addr,
  input  logic [I_SIZE-1:0] mem_rdata,
  input  logic              jmp_sel,
  input  logic              jmpr_sel,
  input  logic [A_SIZE-1:0] jmp,
  input  logic [A_SIZE-1:0] jmp_offset,
  input  logic [A_SIZE-1:0] br_pc,
  input  logic              freeze,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [I_SIZE-1:0] instr_out,
  output logic [A_SIZE-1:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = A_SIZE + I_SIZE;

  logic [1:0]        state_q, state_d;
  logic [A_SIZE-1:0] pc_q, pc_d;
  logic [A_SIZE-1:0] pend_pc_q, pend_pc_d;
  logic              inflight_q;

  logic              redirect;
  logic [A_SIZE-1:0] target;
  logic              credit_ok;
  logic              resp_valid;
  logic              bypass;
  logic              pop;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_head;

  // Redirect decode; relative jump wins over absolute
  assign redirect = jmpr_sel | jmp_sel;
  assign target   = jmpr_sel ? (br_pc + jmp_offset) : jmp;

  // Credit counts in-flight reads so every response has a free slot
  assign credit_ok  = (fifo_count + CW'(inflight_q)) < CW'(DEPTH);
  assign mem_req    = (state_q != IDLE) & ~redirect & ~freeze & credit_ok;
  assign mem_addr   = pc_q;
  assign resp_valid = inflight_q & ~redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = (fifo_count == '0) & resp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = (fifo_count != '0) | bypass;
  assign instr_out   = bypass ? mem_rdata : fifo_head[EW-1:A_SIZE];
  assign instr_pc    = bypass ? pend_pc_q : fifo_head[A_SIZE-1:0];

  assign pop       = instr_valid & instr_ready & ~freeze & ~redirect;
  assign fifo_pop  = pop & ~bypass;
  // A bypassed word that decode takes never enters the queue
  assign fifo_push = resp_valid & ~(bypass & pop);

  // Next-state, PC and pending-PC logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    if (redirect) begin
      state_d = REDIR;
      pc_d    = target;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = RUN;
        REDIR:   state_d = RUN;
        default: state_d = IDLE;
      endcase
      if (mem_req) begin
        pc_d      = pc_q + A_SIZE'(1);
        pend_pc_d = pc_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      pend_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      inflight_q <= mem_req;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .wdata_i ({mem_rdata, pend_pc_q}),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a synchronous memory
// model returning addr + 16'h100. Honours FETCH_BYPASS_EN for latency.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int RLAT = 2;
`else
  localparam int RLAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        jmp_sel;
  logic        jmpr_sel;
  logic [9:0]  jmp;
  logic [9:0]  jmp_offset;
  logic [9:0]  br_pc;
  logic        freeze;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [9:0]  instr_pc;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.A_SIZE(10), .I_SIZE(16), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .jmp_sel     (jmp_sel),
    .jmpr_sel    (jmpr_sel),
    .jmp         (jmp),
    .jmp_offset  (jmp_offset),
    .br_pc       (br_pc),
    .freeze      (freeze),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data valid the cycle after the read
  always @(posedge clk) mem_rdata <= 16'h100 + 16'(mem_addr);

  task automatic cyc();
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks reset outputs, releases into the IDLE cycle
  task automatic test_reset(input logic rdy);
    @(negedge clk);
    jmp_sel = 0; jmpr_sel = 0; jmp = '0; jmp_offset = '0; br_pc = '0;
    freeze = 0; instr_ready = 0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 16'h0 || instr_pc !== 10'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b valid=%b out=%h pc=%h required 0 0 0000 000",
               mem_req, instr_valid, instr_out, instr_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    instr_ready = rdy;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got mem_req=%b required 0", mem_req);
    end
  endtask

  task automatic test_stream();
    test_reset(1'b1);
    cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_first_req: got req=%b addr=%h valid=%b required 1 000 0",
               mem_req, mem_addr, instr_valid);
    end
    for (int d = 2; d < RLAT; d++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_early_valid: got %b required 0", instr_valid);
      end
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(k) || instr_out !== 16'(16'h100 + k)) begin
        errors++;
        $display("FAIL stream_word%0d: got valid=%b pc=%h out=%h required 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, 10'(k), 16'(16'h100 + k));
      end
    end
  endtask

  task automatic test_backpressure();
    test_reset(1'b0);
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 10'h4 || instr_valid !== 1'b1 ||
        instr_pc !== 10'h0 || instr_out !== 16'h100) begin
      errors++;
      $display("FAIL bp_full: got req=%b addr=%h valid=%b pc=%h out=%h required 0 004 1 000 0100",
               mem_req, mem_addr, instr_valid, instr_pc, instr_out);
    end
    cyc();
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(k) || instr_out !== 16'(16'h100 + k)) begin
        errors++;
        $display("FAIL bp_drain%0d: got valid=%b pc=%h out=%h required 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, 10'(k), 16'(16'h100 + k));
      end
      cyc();
    end
  endtask

  task automatic test_jump();
    test_reset(1'b0);
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h3) begin
      errors++;
      $display("FAIL jmp_pre_req: got req=%b addr=%h required 1 003", mem_req, mem_addr);
    end
    cyc();
    jmp_sel = 1'b1; jmp = 10'h2A; instr_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jmp_req_forced: got mem_req=%b required 0", mem_req);
    end
    cyc();
    jmp_sel = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h2A) begin
      errors++;
      $display("FAIL jmp_flush: got valid=%b req=%b addr=%h required 0 1 02a",
               instr_valid, mem_req, mem_addr);
    end
    for (int d = 2; d < RLAT; d++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL jmp_early_valid: got %b required 0", instr_valid);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(10'h2A + k) || instr_out !== 16'(16'h12A + k)) begin
        errors++;
        $display("FAIL jmp_word%0d: got valid=%b pc=%h out=%h required 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, 10'(10'h2A + k), 16'(16'h12A + k));
      end
    end
  endtask

  task automatic test_jmpr_wrap();
    test_reset(1'b1);
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 10'(5 - RLAT)) begin
      errors++;
      $display("FAIL jmpr_pre_head: got valid=%b pc=%h required 1 %h",
               instr_valid, instr_pc, 10'(5 - RLAT));
    end
    jmpr_sel = 1'b1; jmp_sel = 1'b1; jmp = 10'h155; br_pc = 10'h3FE; jmp_offset = 10'h005;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jmpr_req_forced: got mem_req=%b required 0", mem_req);
    end
    cyc();
    jmpr_sel = 1'b0; jmp_sel = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h003) begin
      errors++;
      $display("FAIL jmpr_target: got valid=%b req=%b addr=%h required 0 1 003",
               instr_valid, mem_req, mem_addr);
    end
    for (int d = 2; d < RLAT; d++) cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(3 + k) || instr_out !== 16'(16'h103 + k)) begin
        errors++;
        $display("FAIL jmpr_word%0d: got valid=%b pc=%h out=%h required 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, 10'(3 + k), 16'(16'h103 + k));
      end
    end
  endtask

  task automatic test_freeze();
    test_reset(1'b1);
    cyc();
    cyc();
    freeze = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL frz_no_req: got mem_req=%b required 0", mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'h0 || instr_out !== 16'h100 ||
          mem_req !== 1'b0 || mem_addr !== 10'h1) begin
        errors++;
        $display("FAIL frz_hold%0d: got valid=%b pc=%h out=%h req=%b addr=%h required 1 000 0100 0 001",
                 i, instr_valid, instr_pc, instr_out, mem_req, mem_addr);
      end
    end
    jmp_sel = 1'b1; jmp = 10'h2A;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL frz_jmp_req: got mem_req=%b required 0", mem_req);
    end
    cyc();
    jmp_sel = 1'b0; freeze = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h2A) begin
      errors++;
      $display("FAIL frz_jmp_flush: got valid=%b req=%b addr=%h required 0 1 02a",
               instr_valid, mem_req, mem_addr);
    end
    for (int d = 2; d < RLAT; d++) cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(10'h2A + k) || instr_out !== 16'(16'h12A + k)) begin
        errors++;
        $display("FAIL frz_word%0d: got valid=%b pc=%h out=%h required 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, 10'(10'h2A + k), 16'(16'h12A + k));
      end
    end
  endtask

  task automatic test_redirect_latency();
    test_reset(1'b1);
    for (int i = 0; i < 6; i++) cyc();
    jmp_sel = 1'b1; jmp = 10'h40;
    cyc();
    jmp_sel = 1'b0;
    for (int d = 2; d < RLAT; d++) cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(10'h40 + k) || instr_out !== 16'(16'h140 + k)) begin
        errors++;
        $display("FAIL redir40_word%0d: got valid=%b pc=%h out=%h required 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, 10'(10'h40 + k), 16'(16'h140 + k));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    jmp_sel = 0; jmpr_sel = 0; jmp = '0; jmp_offset = '0; br_pc = '0;
    freeze = 0; instr_ready = 0;
    test_reset(1'b0);
    test_stream();
    test_backpressure();
    test_jump();
    test_jmpr_wrap();
    test_freeze();
    test_redirect_latency();
    test_reset(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-PC fetch stage: a PC generator plus a DEPTH-entry instruction prefetch queue between synchronous program memory and decode.
- Issues one read per cycle when credit allows, buffers returned words with their PCs, and presents them to decode through a valid/ready handshake.
- Handles absolute and PC-relative jump redirects (queue flush) and a global freeze.

Parameters:
- A_SIZE, 10, program address / PC width
- I_SIZE, 16, instruction width
- DEPTH, 4, queue entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- mem_req  out  1  read strobe to program memory
- mem_addr  out  A_SIZE  read address; equals pc
- mem_rdata  in  I_SIZE  read data, valid the cycle after an accepted mem_req
- jmp_sel  in  1  absolute redirect to jmp
- jmpr_sel  in  1  relative redirect to br_pc+jmp_offset (wins over jmp_sel)
- jmp  in  A_SIZE  absolute target
- jmp_offset  in  A_SIZE  relative offset, two's complement
- br_pc  in  A_SIZE  PC of the jumping instruction
- freeze  in  1  hold PC, no issue, no pop
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr_out  out  I_SIZE  head instruction
- instr_pc  out  A_SIZE  head PC

Behaviour:
- Reset (async, rst=0): pc=0, queue empty, inflight=0, state=IDLE; mem_req=0, instr_valid=0, instr_out=0, instr_pc=0.
- FSM:
  - IDLE: one cycle after reset release, no request; then RUN.
  - RUN: normal operation.
  - REDIR: entered for one cycle after a redirect; issues from the new pc, then RUN.
  - A redirect in any state moves to REDIR.
- redirect = jmpr_sel|jmp_sel. Target = br_pc+jmp_offset (mod 2^A_SIZE) if jmpr_sel, else jmp.
- Redirect priority is above freeze.
- Redirect cycle N:
  - mem_req forced 0 combinationally.
  - Any response arriving in N is discarded.
  - Queue cleared and inflight=0 at the edge ending N; pc<=target.
  - No pop occurs in N even if instr_ready.
- Issue: mem_req = state!=IDLE & ~redirect & ~freeze & (count+inflight < DEPTH).
  - inflight is the registered value of mem_req.
  - On issue: pc<=pc+1 (wraps at 2^A_SIZE); the issued pc is held in a one-entry pending-PC register.
- Response: when inflight=1 and no redirect, write {mem_rdata, pending pc} to the tail.
  - Writes happen even under freeze; credit guarantees space, so the queue never overflows.
- Pop: when instr_valid & instr_ready & ~freeze & ~redirect.
  - Push and pop in the same cycle leave count unchanged.
- instr_valid = count!=0. Outputs come from registered queue storage (no bypass unless the optional feature is enabled).
- Latency:
  - Redirect in N -> mem_req(target) in N+1 -> data in N+2 -> instr_valid with instr_pc=target in N+3.
  - Steady state: one instruction per cycle with instr_ready held high.
- Freeze: pc, count and outputs hold, except for the inflight write described above.
- Reset asserted mid-operation: immediate return to reset values; no partial state survives.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- When defined: if the queue is empty and a valid response arrives (no redirect), instr_valid=1 combinationally with instr_out=mem_rdata and instr_pc=pending pc in that cycle. If that word is accepted, it is not written to the queue. Redirect-to-valid latency becomes 2 cycles.
- Without the macro: responses always go through the queue (3-cycle latency).

Decomposition:
- Package fetch_pkg:
  - A_SIZE/I_SIZE defaults
  - state encoding IDLE=2'd0, RUN=2'd1, REDIR=2'd2
  - queue entry struct {pc, instr}
  - NOP opcode constant
- One sub-module, fetch_fifo: DEPTH-entry circular buffer with push, pop, flush, count and head outputs. PC/FSM/credit logic stays in fetch_queue.

Test Plan:
- Reset, then instr_ready=1 and memory returning data=addr+16'h100 -> first instr_valid 3 cycles after IDLE exits, instr_pc=0,1,2,..., instr_out=16'h100,16'h101,...
- instr_ready=0 for 10 cycles -> mem_req stops once count+inflight=4; count=4, no overflow, pc=4; releasing ready resumes 1/cycle with no gap after refill.
- jmp_sel=1, jmp=10'h2A while the queue holds 3 entries -> same cycle mem_req=0 and the response is dropped; queue empty next cycle; instr_pc=10'h2A 3 cycles later.
- jmpr_sel=1 and jmp_sel=1, br_pc=10'h3FE, jmp_offset=10'h005 -> target 10'h003 (wrap); jmpr wins.
- freeze=1 for 5 cycles with one request in flight -> that response is written, pc unchanged, no pops; redirect during freeze still flushes.
- FETCH_BYPASS_EN build: redirect to 10'h40 -> instr_valid with instr_pc=10'h40 2 cycles later; the queue stays empty under continuous ready.
